bus_owner_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the 2:1 register-to-bus select path. Two register-side requesters (R0 side, R1 side) compete for the shared 16-bit bus.
- Drives SEL_BUS into the bus mux and per-requester grants.
- Enforces a maximum hold time under contention and a programmable dead (turnaround) window between owners, so the bus is never marked valid while it is switching.

---
 rtl/bus_owner_arbiter.sv | 109 ++++++++++
 tb/tb_bus_owner_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bus_owner_arbiter.sv
// Round-robin owner arbiter for the 2:1 register-to-bus select path.
// Hold limit under contention and a turnaround gap keep the bus invalid while switching.
module bus_owner_arbiter #(
  parameter int unsigned HOLD_MAX = 4,
  parameter int unsigned TURN_CYC = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ0,
  input  logic       REQ1,
  output logic       GNT0,
  output logic       GNT1,
  output logic       SEL_BUS,
  output logic       BUS_VALID,
  output logic [7:0] SWITCH_CNT
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, TURN} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);

  state_t     state, state_n;
  logic       last, last_n;
  logic [7:0] hold_cnt, hold_n;
  logic [3:0] turn_cnt, turn_n;
  logic       sel_n;
  logic [7:0] sw_n;

  logic arb_any, arb_pick, arbitrate;
  logic owner, req_own, req_oth;

  always_comb begin
    arb_any   = REQ0 | REQ1;
    arb_pick  = (REQ0 & REQ1) ? ~last : REQ1;
    arbitrate = (state == IDLE) || ((state == TURN) && (turn_cnt == TURN_LAST));
    owner     = (state == GRANT1);
    req_own   = owner ? REQ1 : REQ0;
    req_oth   = owner ? REQ0 : REQ1;
  end

  always_comb begin
    state_n = state;
    last_n  = last;
    hold_n  = hold_cnt;
    turn_n  = turn_cnt;
    sel_n   = SEL_BUS;
    sw_n    = SWITCH_CNT;

    // IDLE and the final TURN cycle share one arbitration; TURN uses the LAST set at exit
    if (arbitrate) begin
      state_n = IDLE;
      if (arb_any) begin
        state_n = arb_pick ? GRANT1 : GRANT0;
        sel_n   = arb_pick;
        hold_n  = '0;
      end
    end else begin
      case (state)
        TURN: turn_n = turn_cnt + 4'd1;
        GRANT0, GRANT1: begin
          if (hold_cnt != '1) hold_n = hold_cnt + 8'd1;
          if (!req_own || (req_oth && (hold_cnt == HOLD_LAST))) begin
            last_n = owner;
            sw_n   = SWITCH_CNT + 8'd1;
            if (req_oth) begin
              sel_n = ~owner;
              if (TURN_CYC > 0) begin
                state_n = TURN;
                turn_n  = '0;
              end else begin
                state_n = owner ? GRANT0 : GRANT1;
                hold_n  = '0;
              end
            end else begin
              state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      last       <= 1'b1;
      hold_cnt   <= '0;
      turn_cnt   <= '0;
      SEL_BUS    <= 1'b0;
      SWITCH_CNT <= '0;
      GNT0       <= 1'b0;
      GNT1       <= 1'b0;
      BUS_VALID  <= 1'b0;
    end else begin
      state      <= state_n;
      last       <= last_n;
      hold_cnt   <= hold_n;
      turn_cnt   <= turn_n;
      SEL_BUS    <= sel_n;
      SWITCH_CNT <= sw_n;
      GNT0       <= (state_n == GRANT0);
      GNT1       <= (state_n == GRANT1);
      BUS_VALID  <= (state_n == GRANT0) || (state_n == GRANT1);
    end
  end

endmodule

// File: tb/tb_bus_owner_arbiter.sv
// Directed bench for bus_owner_arbiter: default instance plus a HOLD_MAX=2, TURN_CYC=0 instance.
module tb_bus_owner_arbiter;

  logic       CLK = 1'b0;
  logic       RST, REQ0, REQ1;
  logic       gnt0_a, gnt1_a, sel_a, valid_a;
  logic       gnt0_b, gnt1_b, sel_b, valid_b;
  logic [7:0] sw_a, sw_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  bus_owner_arbiter #(.HOLD_MAX(4), .TURN_CYC(1)) dut_a (
    .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1),
    .GNT0(gnt0_a), .GNT1(gnt1_a), .SEL_BUS(sel_a), .BUS_VALID(valid_a),
    .SWITCH_CNT(sw_a)
  );

  bus_owner_arbiter #(.HOLD_MAX(2), .TURN_CYC(0)) dut_b (
    .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1),
    .GNT0(gnt0_b), .GNT1(gnt1_b), .SEL_BUS(sel_b), .BUS_VALID(valid_b),
    .SWITCH_CNT(sw_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, sample 1 ns later, and check the always-true properties.
  task automatic step();
    logic pv, ps;
    pv = valid_a;
    ps = sel_a;
    @(posedge CLK);
    #1;
    chk("mutex_a", {31'b0, gnt0_a & gnt1_a}, 0);
    chk("valid_a", {31'b0, valid_a}, {31'b0, gnt0_a | gnt1_a});
    chk("mutex_b", {31'b0, gnt0_b & gnt1_b}, 0);
    chk("valid_b", {31'b0, valid_b}, {31'b0, gnt0_b | gnt1_b});
    if (pv && valid_a) chk("sel_stable_a", {31'b0, sel_a}, {31'b0, ps});
  endtask

  task automatic do_reset();
    RST  = 1'b1;
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    step();
    RST = 1'b0;
  endtask

  initial begin
    RST  = 1'b1;
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    step();
    step();
    RST = 1'b0;
    chk("rst_gnt0", {31'b0, gnt0_a}, 0);
    chk("rst_gnt1", {31'b0, gnt1_a}, 0);
    chk("rst_sel", {31'b0, sel_a}, 0);
    chk("rst_valid", {31'b0, valid_a}, 0);
    chk("rst_sw", {24'b0, sw_a}, 0);

    // Solo requester 0: one-cycle latency, long hold, release
    REQ0 = 1'b1;
    step();
    chk("t1_gnt0", {31'b0, gnt0_a}, 1);
    chk("t1_sel", {31'b0, sel_a}, 0);
    chk("t1_valid", {31'b0, valid_a}, 1);
    repeat (19) step();
    chk("t1_hold20", {31'b0, gnt0_a}, 1);
    chk("t1_sw_hold", {24'b0, sw_a}, 0);
    REQ0 = 1'b0;
    step();
    chk("t1_rel_gnt0", {31'b0, gnt0_a}, 0);
    chk("t1_rel_valid", {31'b0, valid_a}, 0);
    chk("t1_rel_sw", {24'b0, sw_a}, 1);

    // Continuous dual request: A period 10 (4 grant + 1 dead), B period 4 direct handover
    do_reset();
    REQ0 = 1'b1;
    REQ1 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      int p;
      step();
      p = k % 10;
      chk("t2_gnt0", {31'b0, gnt0_a}, (p < 4) ? 1 : 0);
      chk("t2_gnt1", {31'b0, gnt1_a}, (p >= 5 && p < 9) ? 1 : 0);
      chk("t2_sel", {31'b0, sel_a}, (p >= 4 && p < 9) ? 1 : 0);
      chk("t2_sw", {24'b0, sw_a}, (k + 1) / 5);
      chk("t3_gnt0", {31'b0, gnt0_b}, ((k / 2) % 2 == 0) ? 1 : 0);
      chk("t3_gnt1", {31'b0, gnt1_b}, ((k / 2) % 2 == 1) ? 1 : 0);
      chk("t3_sel", {31'b0, sel_b}, (k / 2) % 2);
      chk("t3_valid", {31'b0, valid_b}, 1);
      chk("t3_sw", {24'b0, sw_b}, k / 2);
    end

    // Incoming side drops during turnaround: old owner re-granted
    do_reset();
    REQ0 = 1'b1;
    REQ1 = 1'b1;
    repeat (5) step();
    chk("t4_turn_sel", {31'b0, sel_a}, 1);
    chk("t4_turn_valid", {31'b0, valid_a}, 0);
    REQ1 = 1'b0;
    step();
    chk("t4_regrant0", {31'b0, gnt0_a}, 1);
    chk("t4_sel", {31'b0, sel_a}, 0);
    chk("t4_sw", {24'b0, sw_a}, 1);
    repeat (6) begin
      step();
      chk("t4_no_gnt1", {31'b0, gnt1_a}, 0);
      chk("t4_keep0", {31'b0, gnt0_a}, 1);
    end

    // Reset mid GRANT1 with HOLD_CNT=2, then tie goes to requester 0
    do_reset();
    REQ0 = 1'b1;
    REQ1 = 1'b1;
    repeat (8) step();
    chk("t5_pre_gnt1", {31'b0, gnt1_a}, 1);
    chk("t5_pre_hold", {24'b0, dut_a.hold_cnt}, 2);
    RST = 1'b1;
    step();
    chk("t5_rst_gnt0", {31'b0, gnt0_a}, 0);
    chk("t5_rst_gnt1", {31'b0, gnt1_a}, 0);
    chk("t5_rst_sel", {31'b0, sel_a}, 0);
    chk("t5_rst_valid", {31'b0, valid_a}, 0);
    chk("t5_rst_sw", {24'b0, sw_a}, 0);
    RST = 1'b0;
    step();
    chk("t5_tie_gnt0", {31'b0, gnt0_a}, 1);
    chk("t5_tie_gnt1", {31'b0, gnt1_a}, 0);

    // SWITCH_CNT wrap, then HOLD_CNT saturation on a long solo hold
    do_reset();
    for (int i = 0; i < 256; i++) begin
      REQ0 = 1'b1;
      step();
      REQ0 = 1'b0;
      step();
      if (i == 254) chk("t6_sw255", {24'b0, sw_a}, 255);
    end
    chk("t6_wrap", {24'b0, sw_a}, 0);
    REQ1 = 1'b1;
    step();
    repeat (300) step();
    chk("t6_solo_gnt1", {31'b0, gnt1_a}, 1);
    chk("t6_hold_sat", {24'b0, dut_a.hold_cnt}, 255);
    REQ1 = 1'b0;
    step();
    chk("t6_rel_gnt1", {31'b0, gnt1_a}, 0);
    chk("t6_rel_sw", {24'b0, sw_a}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
